// File: rtl/timer_sched_ctrl.sv
// Shared prescaled free-running counter with NUM_CH one-shot/periodic compare channels.
// Define TIMER_SCHED_CAPTURE_EN to add the cap_in capture channel on PEND/IEN bit NUM_CH.
module timer_sched_ctrl #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             we,
    input  logic [3:0]       addr,
    input  logic [CNT_W-1:0] wdata,
    output logic [CNT_W-1:0] rdata,
    output logic             ack,
    output logic             irq
`ifdef TIMER_SCHED_CAPTURE_EN
    ,
    input  logic             cap_in
`endif
);

`ifdef TIMER_SCHED_CAPTURE_EN
    localparam int PW = NUM_CH + 1;
`else
    localparam int PW = NUM_CH;
`endif
    localparam logic [CNT_W-1:0]   CNT_ONE   = 1;
    localparam logic [PRESC_W-1:0] PRESC_ONE = 1;

    logic               r_en;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_presc_cnt;
    logic [CNT_W-1:0]   r_count;
    logic [PW-1:0]      r_pend;
    logic [PW-1:0]      r_ien;
    logic [NUM_CH-1:0]  r_mode;
    logic [NUM_CH-1:0]  r_arm;
    logic [CNT_W-1:0]   r_cmp    [NUM_CH];
    logic [CNT_W-1:0]   r_period [NUM_CH];
    logic [CNT_W-1:0]   r_rdata;
    logic               r_ack;

    logic               w_wr;
    logic               w_wr_cnt;
    logic               w_tick;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [NUM_CH-1:0]  w_hit;
    logic [PW-1:0]      w_set;
    logic [PW-1:0]      w_w1c;
    logic [1:0]         w_idx;
    logic               w_idx_ok;
    logic [CNT_W-1:0]   w_capture;
    logic [CNT_W-1:0]   w_rd;

    assign w_wr      = req & we;
    assign w_wr_cnt  = w_wr && (addr == 4'h1);
    assign w_tick    = r_en && (r_presc_cnt == r_presc);
    assign w_cnt_inc = r_count + CNT_ONE;
    assign w_w1c     = (w_wr && (addr == 4'h2)) ? wdata[PW-1:0] : '0;
    assign w_idx     = addr[1:0];
    assign w_idx_ok  = int'(w_idx) < NUM_CH;

    // A software COUNT write on a tick edge suppresses both the increment and any match.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_hit[i] = w_tick && !w_wr_cnt && r_arm[i] && (w_cnt_inc == r_cmp[i]);
        end
    end

`ifdef TIMER_SCHED_CAPTURE_EN
    logic [2:0]       r_cap_sync;
    logic [CNT_W-1:0] r_capture;
    logic             w_cap_rise;

    // Two synchroniser flops, the third only remembers the previous level for edge detection.
    assign w_cap_rise = r_cap_sync[1] & ~r_cap_sync[2];
    assign w_set      = {w_cap_rise, w_hit};
    assign w_capture  = r_capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap_sync <= '0;
            r_capture  <= '0;
        end else begin
            r_cap_sync <= {r_cap_sync[1:0], cap_in};
            if (w_cap_rise) begin
                r_capture <= r_count;
            end
        end
    end
`else
    assign w_set     = w_hit;
    assign w_capture = '0;
`endif

    always_comb begin
        w_rd = '0;
        case (addr)
            4'h0:    w_rd = CNT_W'({r_presc, 7'd0, r_en});
            4'h1:    w_rd = r_count;
            4'h2:    w_rd = CNT_W'(r_pend);
            4'h3:    w_rd = CNT_W'(r_ien);
            4'h4:    w_rd = CNT_W'(r_mode);
            4'h5:    w_rd = CNT_W'(r_arm);
            4'h6:    w_rd = w_capture;
            default: begin
                if (addr[3] && w_idx_ok) begin
                    w_rd = addr[2] ? r_period[w_idx] : r_cmp[w_idx];
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en        <= 1'b0;
            r_presc     <= '0;
            r_presc_cnt <= '0;
            r_count     <= '0;
            r_pend      <= '0;
            r_ien       <= '0;
            r_mode      <= '0;
            r_arm       <= '0;
            r_rdata     <= '0;
            r_ack       <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_cmp[i]    <= '0;
                r_period[i] <= '0;
            end
        end else begin
            r_ack   <= req;
            r_rdata <= req ? w_rd : '0;

            if (r_en) begin
                r_presc_cnt <= w_tick ? '0 : r_presc_cnt + PRESC_ONE;
            end

            if (w_wr_cnt) begin
                r_count <= wdata;
            end else if (w_tick) begin
                r_count <= w_cnt_inc;
            end

            // Hardware set takes priority over a same-edge write-one-to-clear.
            r_pend <= (r_pend & ~w_w1c) | w_set;

            if (w_wr && (addr == 4'h0)) begin
                r_en    <= wdata[0];
                r_presc <= wdata[PRESC_W+7:8];
            end
            if (w_wr && (addr == 4'h3)) begin
                r_ien <= wdata[PW-1:0];
            end
            if (w_wr && (addr == 4'h4)) begin
                r_mode <= wdata[NUM_CH-1:0];
            end

            if (w_wr && (addr == 4'h5)) begin
                r_arm <= wdata[NUM_CH-1:0];
            end else begin
                r_arm <= r_arm & ~(w_hit & ~r_mode);
            end

            for (int i = 0; i < NUM_CH; i++) begin
                if (w_wr && (addr == 4'(8 + i))) begin
                    r_cmp[i] <= wdata;
                end else if (w_hit[i] && r_mode[i]) begin
                    r_cmp[i] <= r_cmp[i] + r_period[i];
                end
                if (w_wr && (addr == 4'(12 + i))) begin
                    r_period[i] <= wdata;
                end
            end
        end
    end

    assign rdata = r_rdata;
    assign ack   = r_ack;
    assign irq   = |(r_pend & r_ien);

endmodule

// File: tb/tb_timer_sched_ctrl.sv
// Bench for timer_sched_ctrl: register table, directed timing sequences and a randomized run
// against a cycle-level behavioural model; honours TIMER_SCHED_CAPTURE_EN like the design.
module tb_timer_sched_ctrl;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 32;
    localparam int PRESC_W = 8;
`ifdef TIMER_SCHED_CAPTURE_EN
    localparam int PW = NUM_CH + 1;
`else
    localparam int PW = NUM_CH;
`endif
    localparam logic [31:0] CHMASK = (32'd1 << NUM_CH) - 32'd1;
    localparam logic [31:0] PMASK  = (32'd1 << PW) - 32'd1;

    logic             clk;
    logic             rst;
    logic             req;
    logic             we;
    logic [3:0]       addr;
    logic [CNT_W-1:0] wdata;
    logic [CNT_W-1:0] rdata;
    logic             ack;
    logic             irq;
`ifdef TIMER_SCHED_CAPTURE_EN
    logic             cap_in;
`endif

    timer_sched_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ack   (ack),
        .irq   (irq)
`ifdef TIMER_SCHED_CAPTURE_EN
        ,
        .cap_in(cap_in)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string nm, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Behavioural reference: register file plus the counting/firing rules, evaluated per edge.
    logic               m_en;
    logic [PRESC_W-1:0] m_presc;
    logic [PRESC_W-1:0] m_pc;
    logic [CNT_W-1:0]   m_count;
    logic [CNT_W-1:0]   m_cap;
    logic [CNT_W-1:0]   m_rdata;
    logic               m_ack;
    logic [31:0]        m_pend;
    logic [31:0]        m_ien;
    logic [31:0]        m_mode;
    logic [31:0]        m_arm;
    logic [CNT_W-1:0]   m_cmp [NUM_CH];
    logic [CNT_W-1:0]   m_per [NUM_CH];
    logic [2:0]         m_sync;
    logic               mw;
    logic               mtick;
    logic               mcap_rise;
    logic [31:0]        mhit;
    logic [CNT_W-1:0]   mnext;

    function automatic logic [CNT_W-1:0] m_read(input logic [3:0] a);
        int ch;
        ch = int'(a[1:0]);
        case (a)
            4'h0: return (CNT_W'(m_presc) << 8) | CNT_W'(m_en);
            4'h1: return m_count;
            4'h2: return m_pend;
            4'h3: return m_ien;
            4'h4: return m_mode;
            4'h5: return m_arm;
            4'h6: return m_cap;
            default: begin
                if (a >= 4'h8 && ch < NUM_CH) return (a >= 4'hC) ? m_per[ch] : m_cmp[ch];
            end
        endcase
        return '0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_en = 1'b0; m_presc = '0; m_pc = '0; m_count = '0; m_cap = '0;
            m_rdata = '0; m_ack = 1'b0; m_pend = '0; m_ien = '0; m_mode = '0;
            m_arm = '0; m_sync = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_cmp[i] = '0;
                m_per[i] = '0;
            end
        end else begin
            mw      = req && we;
            m_rdata = req ? m_read(addr) : '0;
            m_ack   = req;
            mtick   = m_en && (m_pc == m_presc);
            mnext   = m_count + 32'd1;
            mhit    = '0;
            if (mtick && !(mw && addr == 4'h1)) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (m_arm[i] && mnext == m_cmp[i]) mhit[i] = 1'b1;
                end
            end
            mcap_rise = 1'b0;
`ifdef TIMER_SCHED_CAPTURE_EN
            mcap_rise = m_sync[1] && !m_sync[2];
            if (mcap_rise) m_cap = m_count;
            m_sync = {m_sync[1:0], cap_in};
`endif
            if (m_en) m_pc = mtick ? '0 : m_pc + 8'd1;
            if (mtick) m_count = mnext;
            for (int i = 0; i < NUM_CH; i++) begin
                if (mhit[i]) begin
                    if (m_mode[i]) m_cmp[i] = m_cmp[i] + m_per[i];
                    else           m_arm[i] = 1'b0;
                end
            end
            if (mw && addr == 4'h2) m_pend = m_pend & ~wdata;
            m_pend = m_pend | mhit | (mcap_rise ? (32'd1 << NUM_CH) : 32'd0);
            if (mw) begin
                case (addr)
                    4'h0: begin m_en = wdata[0]; m_presc = wdata[PRESC_W+7:8]; end
                    4'h1: m_count = wdata;
                    4'h3: m_ien  = wdata & PMASK;
                    4'h4: m_mode = wdata & CHMASK;
                    4'h5: m_arm  = wdata & CHMASK;
                    default: begin
                        if (addr >= 4'h8 && int'(addr[1:0]) < NUM_CH) begin
                            if (addr >= 4'hC) m_per[addr[1:0]] = wdata;
                            else              m_cmp[addr[1:0]] = wdata;
                        end
                    end
                endcase
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en && !rst) begin
            check("mon_ack", CNT_W'(ack), CNT_W'(m_ack));
            check("mon_rdata", rdata, m_rdata);
            check("mon_irq", CNT_W'(irq), CNT_W'((m_pend & m_ien) != 32'd0));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic acc(input logic w, input logic [3:0] a, input logic [CNT_W-1:0] d,
                       output logic [CNT_W-1:0] r);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0;
        r = rdata;
    endtask

    task automatic wr(input logic [3:0] a, input logic [CNT_W-1:0] d);
        logic [CNT_W-1:0] r;
        acc(1'b1, a, d, r);
    endtask

    task automatic rdchk(input string nm, input logic [3:0] a, input logic [CNT_W-1:0] e);
        logic [CNT_W-1:0] r;
        acc(1'b0, a, '0, r);
        check(nm, r, e);
        check({nm, "_ack"}, CNT_W'(ack), 1);
    endtask

    task automatic do_reset();
        req = 1'b0; we = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic        w;
        logic [3:0]  a;
        logic [31:0] d;
        logic [31:0] e;
    } vec_t;
    vec_t tbl[$];

    task automatic addv(input logic w, input logic [3:0] a, input logic [31:0] d, input logic [31:0] e);
        vec_t v;
        v.w = w; v.a = a; v.d = d; v.e = e;
        tbl.push_back(v);
    endtask

    logic [CNT_W-1:0] r;
    logic [CNT_W-1:0] rd_d;
    logic [3:0]       ra;
    logic             rw;

    initial begin
        rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
`ifdef TIMER_SCHED_CAPTURE_EN
        cap_in = 1'b0;
`endif
        addv(1'b1, 4'h8, 32'd10,         32'd0);
        addv(1'b0, 4'h8, 32'd0,          32'd10);
        addv(1'b1, 4'hF, 32'hDEADBEEF,   32'd0);
        addv(1'b0, 4'hF, 32'd0,          32'hDEADBEEF);
        addv(1'b1, 4'h7, 32'd1234,       32'd0);
        addv(1'b0, 4'h7, 32'd0,          32'd0);
        addv(1'b1, 4'h4, 32'hFF,         32'd0);
        addv(1'b0, 4'h4, 32'd0,          CHMASK);
        addv(1'b1, 4'h5, 32'hFFFFFFFF,   32'd0);
        addv(1'b0, 4'h5, 32'd0,          CHMASK);
        addv(1'b1, 4'h3, 32'hFFFFFFFF,   32'd0);
        addv(1'b0, 4'h3, 32'd0,          PMASK);
        addv(1'b1, 4'h2, 32'hFF,         32'd0);
        addv(1'b0, 4'h2, 32'd0,          32'd0);
        addv(1'b1, 4'h0, 32'hFFFFFFFE,   32'd0);
        addv(1'b0, 4'h0, 32'd0,          32'h0000FF00);
        addv(1'b1, 4'h1, 32'd123,        32'd0);
        addv(1'b0, 4'h1, 32'd0,          32'd123);
        addv(1'b1, 4'h6, 32'd99,         32'd0);
        addv(1'b0, 4'h6, 32'd0,          32'd0);
        addv(1'b0, 4'hE, 32'd0,          32'd0);

        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // Every register reads zero after reset; ack lasts exactly one cycle.
        for (int a = 0; a < 16; a++) begin
            acc(1'b0, 4'(a), '0, r);
            check($sformatf("rst_rd_%0h", a), r, 0);
            check("rst_ack", CNT_W'(ack), 1);
            check("rst_irq", CNT_W'(irq), 0);
            step(1);
            check("rst_ack_drop", CNT_W'(ack), 0);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            acc(tbl[i].w, tbl[i].a, tbl[i].d, r);
            check($sformatf("tbl_ack_%0d", i), CNT_W'(ack), 1);
            if (!tbl[i].w) check($sformatf("tbl_rd_%0d", i), r, tbl[i].e);
        end

        // Prescaler 3: five ticks in twenty cycles, then frozen by EN=0.
        do_reset();
        wr(4'h1, 32'd0);
        wr(4'h0, 32'h301);
        step(20);
        rdchk("presc_count5", 4'h1, 32'd5);
        wr(4'h0, 32'h300);
        step(10);
        rdchk("presc_hold5", 4'h1, 32'd5);

        // One-shot channel 0 at COUNT=10.
        do_reset();
        wr(4'h8, 32'd10);
        wr(4'h3, 32'd1);
        wr(4'h5, 32'd1);
        wr(4'h0, 32'd1);
        step(9);
        check("os_irq_before", CNT_W'(irq), 0);
        step(1);
        check("os_irq_fire", CNT_W'(irq), 1);
        rdchk("os_pend", 4'h2, 32'd1);
        rdchk("os_arm_clr", 4'h5, 32'd0);
        wr(4'h2, 32'd1);
        check("os_irq_w1c", CNT_W'(irq), 0);
        step(10);
        check("os_no_refire", CNT_W'(irq), 0);
        rdchk("os_pend_clr", 4'h2, 32'd0);
        rdchk("os_count", 4'h1, 32'd24);

        // Periodic channel 1: fires at 5, 12, 19.
        do_reset();
        wr(4'h9, 32'd5);
        wr(4'hD, 32'd7);
        wr(4'h4, 32'd2);
        wr(4'h3, 32'd2);
        wr(4'h5, 32'd2);
        wr(4'h0, 32'd1);
        step(5);
        check("per_fire5", CNT_W'(irq), 1);
        wr(4'h2, 32'd2);
        check("per_w1c1", CNT_W'(irq), 0);
        step(5);
        check("per_pre12", CNT_W'(irq), 0);
        step(1);
        check("per_fire12", CNT_W'(irq), 1);
        wr(4'h2, 32'd2);
        step(5);
        check("per_pre19", CNT_W'(irq), 0);
        step(1);
        check("per_fire19", CNT_W'(irq), 1);
        rdchk("per_cmp26", 4'h9, 32'd26);
        rdchk("per_arm", 4'h5, 32'd2);

        // W1C colliding with a fire, then a COUNT write on a tick edge.
        do_reset();
        wr(4'h8, 32'd3);
        wr(4'h3, 32'd1);
        wr(4'h5, 32'd1);
        wr(4'h0, 32'd1);
        step(2);
        wr(4'h2, 32'd1);
        check("coll_irq", CNT_W'(irq), 1);
        rdchk("coll_pend", 4'h2, 32'd1);
        wr(4'h1, 32'd100);
        rdchk("cntwr_hold", 4'h1, 32'd100);
        rdchk("cntwr_resume", 4'h1, 32'd101);

        // Reset in the middle of an access.
        do_reset();
        wr(4'h1, 32'd55);
        req = 1'b1; we = 1'b0; addr = 4'h1; wdata = '0;
        @(posedge clk);
        #1;
        check("mid_ack_pre", CNT_W'(ack), 1);
        check("mid_rd_pre", rdata, 32'd55);
        we = 1'b1; wdata = 32'd77;
        #1 rst = 1'b1;
        #1;
        check("mid_ack_rst", CNT_W'(ack), 0);
        check("mid_rd_rst", rdata, 0);
        @(posedge clk);
        #1;
        rst = 1'b0; req = 1'b0; we = 1'b0;
        rdchk("mid_wr_dropped", 4'h1, 32'd0);

`ifdef TIMER_SCHED_CAPTURE_EN
        do_reset();
        wr(4'h0, 32'd1);
        step(40);
        cap_in = 1'b1;
        step(1);
        cap_in = 1'b0;
        step(4);
        rdchk("cap_value", 4'h6, 32'd42);
        rdchk("cap_pend", 4'h2, 32'h10);
`endif

        // Randomized traffic; the monitor compares every cycle against the model.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
`ifdef TIMER_SCHED_CAPTURE_EN
            cap_in = ($urandom_range(0, 15) == 0);
`endif
            if ($urandom_range(0, 9) < 6) begin
                ra = 4'($urandom_range(0, 15));
                rw = 1'($urandom_range(0, 1));
                case (ra)
                    4'h0: rd_d = ($urandom_range(0, 3) << 8) | 32'($urandom_range(0, 4) != 0);
                    4'h1: rd_d = m_count + $urandom_range(0, 30);
                    4'h8, 4'h9, 4'hA, 4'hB: rd_d = m_count + $urandom_range(1, 40);
                    4'hC, 4'hD, 4'hE, 4'hF: rd_d = $urandom_range(0, 20);
                    default: rd_d = $urandom;
                endcase
                acc(rw, ra, rd_d, r);
            end else begin
                step(1);
            end
        end
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
